// File: rtl/led_pkg.sv
// Shared types and sizing helpers for the LED pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_COUNT   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_t;

  // speed is 3 bits, so a step can be up to STEP_DIV << 7 cycles long.
  localparam int MAX_SPEED_SHIFT = 7;

  function automatic int presc_width(input int step_div);
    return $clog2(step_div) + MAX_SPEED_SHIFT;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: emits a one-cycle tick every (STEP_DIV << speed_q) enabled cycles.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int STEP_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] speed,
  output logic       tick
);

  localparam int PW = presc_width(STEP_DIV);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] last_count;
  logic [2:0]    speed_q;

  // For power-of-two STEP_DIV the shift at speed 7 overflows to zero; the
  // modular subtraction still yields the correct all-ones terminal count.
  assign last_count = (PW'(STEP_DIV) << speed_q) - PW'(1);
  assign tick       = en && (presc_q == last_count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      speed_q <= '0;
    end else if (en) begin
      if (tick) begin
        presc_q <= '0;
        speed_q <= speed;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Board-status LED driver: blink, chase, binary count or PWM breathe, stepped by led_tick_gen.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED          = 8,
  parameter int STEP_DIV       = 1_000_000,
  parameter int PWM_BITS       = 8,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [2:0]       speed,
  input  logic             dir,
  output logic [N_LED-1:0] prled
);

  localparam logic                OFF_LEVEL = (LED_ACTIVE_LOW != 0);
  localparam logic [PWM_BITS-1:0] DUTY_PRE_PEAK = PWM_BITS'((1 << PWM_BITS) - 2);

  logic                tick;
  led_mode_t           mode_in;
  led_mode_t           mode_q, mode_next;
  logic [N_LED-1:0]    pattern_q, pattern_next;
  logic [PWM_BITS-1:0] duty_q, duty_next;
  logic                rising_q, rising_next;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_on;
  logic                breathe_sel;
  logic [N_LED-1:0]    lit;

  assign mode_in = led_mode_t'(mode);

  led_tick_gen #(
    .STEP_DIV(STEP_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .speed(speed),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_BLINK;
      pattern_q <= '0;
      duty_q    <= '0;
      rising_q  <= 1'b1;
    end else begin
      mode_q    <= mode_next;
      pattern_q <= pattern_next;
      duty_q    <= duty_next;
      rising_q  <= rising_next;
    end
  end

  always_comb begin
    mode_next    = mode_q;
    pattern_next = pattern_q;
    duty_next    = duty_q;
    rising_next  = rising_q;
    if (tick) begin
      if (mode_in != mode_q) begin
        // A mode switch only initialises the new pattern; the first step comes one tick later.
        mode_next    = mode_in;
        pattern_next = '0;
        duty_next    = '0;
        rising_next  = 1'b1;
        if (mode_in == MODE_CHASE) begin
          pattern_next = dir ? {1'b1, {(N_LED-1){1'b0}}} : N_LED'(1);
        end
      end else begin
        unique case (mode_q)
          MODE_BLINK: pattern_next = ~pattern_q;
          MODE_CHASE: pattern_next = dir ? {pattern_q[0], pattern_q[N_LED-1:1]}
                                         : {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
          MODE_COUNT: pattern_next = pattern_q + N_LED'(1);
          MODE_BREATHE: begin
            // Direction flips on arrival at an endpoint so each endpoint lasts one step.
            if (rising_q) begin
              duty_next = duty_q + PWM_BITS'(1);
              if (duty_q == DUTY_PRE_PEAK) rising_next = 1'b0;
            end else begin
              duty_next = duty_q - PWM_BITS'(1);
              if (duty_q == PWM_BITS'(1)) rising_next = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
    end else if (en) begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  assign pwm_on      = (pwm_cnt_q < duty_q);
  assign breathe_sel = (mode_q == MODE_BREATHE);

  for (genvar gi = 0; gi < N_LED; gi++) begin : g_lit
    assign lit[gi] = breathe_sel ? pwm_on : pattern_q[gi];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prled <= {N_LED{OFF_LEVEL}};
    end else begin
      prled <= en ? (lit ^ {N_LED{OFF_LEVEL}}) : {N_LED{OFF_LEVEL}};
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen against a step-level behavioural model.
module tb_led_pattern_gen;

  localparam int N_LED    = 8;
  localparam int STEP_DIV = 4;
  localparam int PWM_BITS = 4;
  localparam int PWM_PER  = 1 << PWM_BITS;
  localparam int RAMP     = 2 * (PWM_PER - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [2:0] speed = 3'd0;
  logic       dir = 1'b0;
  logic [7:0] prled;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .N_LED(N_LED), .STEP_DIV(STEP_DIV), .PWM_BITS(PWM_BITS), .LED_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed), .dir(dir), .prled(prled)
  );

  // Model: position/count/step index in plain integers
  int         m_presc, m_speed, m_mode, m_pos, m_cnt, m_blink, m_bstep, m_pwm;
  logic [7:0] m_led;
  bit         m_tick;

  function automatic int duty_of(input int k);
    int p;
    p = k % RAMP;
    return (p <= PWM_PER - 1) ? p : RAMP - p;
  endfunction

  function automatic logic [7:0] lit_of();
    logic [7:0] one;
    one = 8'h01;
    case (m_mode)
      0:       return (m_blink != 0) ? 8'hFF : 8'h00;
      1:       return one << m_pos;
      2:       return 8'(m_cnt);
      default: return (m_pwm < duty_of(m_bstep)) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_presc = 0; m_speed = 0; m_mode = 0; m_pos = 0; m_cnt = 0;
    m_blink = 0; m_bstep = 0; m_pwm = 0; m_tick = 0; m_led = 8'hFF;
  endtask

  task automatic clk_step();
    logic [7:0] nl;
    bit tk;
    tk = 0;
    if (rst) begin
      nl = en ? ~lit_of() : 8'hFF;
      tk = en && (m_presc == (STEP_DIV << m_speed) - 1);
      if (en) begin
        m_pwm = (m_pwm + 1) % PWM_PER;
        if (tk) begin
          m_presc = 0;
          if (int'(mode) != m_mode) begin
            m_mode = int'(mode); m_blink = 0; m_cnt = 0; m_bstep = 0;
            m_pos = dir ? N_LED - 1 : 0;
          end else begin
            case (m_mode)
              0:       m_blink = 1 - m_blink;
              1:       m_pos = dir ? (m_pos + N_LED - 1) % N_LED : (m_pos + 1) % N_LED;
              2:       m_cnt = (m_cnt + 1) % 256;
              default: m_bstep++;
            endcase
          end
          m_speed = int'(speed);
        end else begin
          m_presc++;
        end
      end
    end else begin
      nl = 8'hFF;
    end
    m_tick = tk;
    @(posedge clk);
    #1;
    m_led = nl;
  endtask

  task automatic run_cycles(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      clk_step();
      if (prled !== m_led) bad++;
    end
  endtask

  task automatic run_to_tick(input int limit, output int ncyc, output int bad, output bit hit);
    ncyc = 0; bad = 0; hit = 0;
    while (!hit && ncyc < limit) begin
      clk_step();
      ncyc++;
      if (prled !== m_led) bad++;
      hit = m_tick;
    end
  endtask

  task automatic test_reset();
    int bad, bad_rst;
    logic [7:0] seen [10];
    rst = 1'b1; en = 1'b1; mode = 2'd0; speed = 3'd0; dir = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (prled !== 8'hFF) begin $display("FAIL reset_async prled=%h expected=ff", prled); errors++; end
    run_cycles(2, bad_rst);
    checks++;
    if (bad_rst != 0) begin $display("FAIL reset_hold mismatches=%0d expected=0", bad_rst); errors++; end
    rst = 1'b1;
    bad = 0;
    for (int e = 1; e <= 9; e++) begin
      clk_step();
      if (prled !== m_led) bad++;
      seen[e] = prled;
    end
    $display("[reset] edges 4/5/8/9 prled=%h %h %h %h", seen[4], seen[5], seen[8], seen[9]);
    checks++;
    if (seen[4] !== 8'hFF) begin $display("FAIL blink_pre_tick prled=%h expected=ff", seen[4]); errors++; end
    checks++;
    if (seen[5] !== 8'h00) begin $display("FAIL blink_first_on prled=%h expected=00", seen[5]); errors++; end
    checks++;
    if (seen[8] !== 8'h00) begin $display("FAIL blink_hold_on prled=%h expected=00", seen[8]); errors++; end
    checks++;
    if (seen[9] !== 8'hFF) begin $display("FAIL blink_back_off prled=%h expected=ff", seen[9]); errors++; end
    checks++;
    if (bad != 0) begin $display("FAIL blink_model mismatches=%0d expected=0", bad); errors++; end
  endtask

  task automatic test_chase();
    int n, bad;
    bit hit;
    logic [7:0] one, exp;
    one = 8'h01;
    mode = 2'd1; dir = 1'b0;
    run_to_tick(100, n, bad, hit);
    clk_step();
    checks++;
    if (!hit || prled !== 8'hFE) begin $display("FAIL chase_init prled=%h expected=fe hit=%0d", prled, hit); errors++; end
    for (int k = 1; k <= 8; k++) begin
      run_to_tick(100, n, bad, hit);
      clk_step();
      exp = ~(one << (k % 8));
      $display("[chase] up step %0d prled=%h", k, prled);
      checks++;
      if (!hit || bad != 0 || prled !== exp) begin
        $display("FAIL chase_up_%0d prled=%h expected=%h hit=%0d bad=%0d", k, prled, exp, hit, bad); errors++;
      end
    end
    dir = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      run_to_tick(100, n, bad, hit);
      clk_step();
      exp = ~(one << (8 - k));
      $display("[chase] down step %0d prled=%h", k, prled);
      checks++;
      if (!hit || bad != 0 || prled !== exp) begin
        $display("FAIL chase_down_%0d prled=%h expected=%h hit=%0d", k, prled, exp, hit); errors++;
      end
    end
    dir = 1'b0;
  endtask

  task automatic test_count();
    int n, bad, badsum, seqbad, ivbad, miss;
    bit hit;
    logic [7:0] exp;
    mode = 2'd2; speed = 3'd2;
    run_to_tick(100, n, bad, hit);
    clk_step();
    checks++;
    if (!hit || prled !== 8'hFF) begin $display("FAIL count_init prled=%h expected=ff", prled); errors++; end
    badsum = 0; seqbad = 0; ivbad = 0; miss = 0;
    for (int k = 1; k <= 256; k++) begin
      run_to_tick(40, n, bad, hit);
      badsum += bad;
      if (!hit) miss++;
      if (n + 1 != 16) ivbad++;
      clk_step();
      if (prled !== m_led) badsum++;
      exp = ~8'(k % 256);
      if (prled !== exp) seqbad++;
      if (k % 64 == 0) $display("[count] step %0d prled=%h", k, prled);
    end
    checks++;
    if (prled !== 8'hFF) begin $display("FAIL count_wrap prled=%h expected=ff", prled); errors++; end
    checks++;
    if (seqbad != 0) begin $display("FAIL count_seq wrong_steps=%0d expected=0", seqbad); errors++; end
    checks++;
    if (ivbad != 0 || miss != 0) begin $display("FAIL count_period bad_intervals=%0d missed=%0d expected=0", ivbad, miss); errors++; end
    checks++;
    if (badsum != 0) begin $display("FAIL count_model mismatches=%0d expected=0", badsum); errors++; end
    run_cycles(5, bad);
    speed = 3'd0;
    run_to_tick(40, n, bad, hit);
    $display("[count] speed change: cycles to tick=%0d", n);
    checks++;
    if (!hit || n != 10) begin $display("FAIL speed_midstep cycles=%0d expected=10", n); errors++; end
    clk_step();
    run_to_tick(40, n, bad, hit);
    checks++;
    if (!hit || n != 3 || bad != 0) begin $display("FAIL speed_new cycles=%0d expected=3 bad=%0d", n, bad); errors++; end
  endtask

  task automatic test_breathe();
    int n, bad, lit_cnt, exp;
    bit hit;
    mode = 2'd3; speed = 3'd2;
    run_to_tick(100, n, bad, hit);
    checks++;
    if (!hit) begin $display("FAIL breathe_enter no tick within bound"); errors++; end
    for (int s = 0; s <= RAMP; s++) begin
      lit_cnt = 0; bad = 0;
      for (int c = 0; c < PWM_PER; c++) begin
        clk_step();
        if (prled === 8'h00) lit_cnt++;
        if (prled !== m_led) bad++;
      end
      exp = (s <= PWM_PER - 1) ? s : RAMP - s;
      $display("[breathe] step %0d lit=%0d of %0d", s, lit_cnt, PWM_PER);
      checks++;
      if (lit_cnt != exp || bad != 0 || !m_tick) begin
        $display("FAIL breathe_step_%0d lit=%0d expected=%0d bad=%0d tick=%0d", s, lit_cnt, exp, bad, m_tick);
        errors++;
      end
    end
  endtask

  task automatic test_en_hold();
    int n, bad, hold, offs;
    bit hit;
    mode = 2'd1; speed = 3'd0; dir = 1'b0;
    run_to_tick(100, n, bad, hit);
    clk_step();
    run_to_tick(100, n, bad, hit);
    clk_step();
    checks++;
    if (prled !== 8'hFD) begin $display("FAIL en_pre prled=%h expected=fd", prled); errors++; end
    clk_step();
    en = 1'b0;
    hold = $urandom_range(3, 10);
    offs = 0;
    for (int i = 0; i < hold; i++) begin
      clk_step();
      if (prled === 8'hFF) offs++;
    end
    $display("[en] held %0d cycles, dark=%0d", hold, offs);
    checks++;
    if (offs != hold) begin $display("FAIL en_off dark=%0d expected=%0d", offs, hold); errors++; end
    en = 1'b1;
    clk_step();
    checks++;
    if (prled !== 8'hFD) begin $display("FAIL en_resume prled=%h expected=fd", prled); errors++; end
    run_to_tick(20, n, bad, hit);
    clk_step();
    checks++;
    if (!hit || n != 1 || prled !== 8'hFB) begin
      $display("FAIL en_remaining cycles=%0d expected=1 prled=%h expected=fb", n, prled); errors++;
    end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    bit hit;
    logic [7:0] seen [6];
    mode = 2'd2; speed = 3'($urandom_range(0, 1));
    run_to_tick(200, n, bad, hit);
    for (int i = 0; i < 3; i++) begin
      run_to_tick(200, n, bad, hit);
      clk_step();
    end
    checks++;
    if (prled !== m_led || prled === 8'hFF) begin $display("FAIL rstmid_pre prled=%h expected=%h", prled, m_led); errors++; end
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (prled !== 8'hFF) begin $display("FAIL rstmid_async prled=%h expected=ff", prled); errors++; end
    run_cycles(2, bad);
    mode = 2'd0;
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      clk_step();
      seen[e] = prled;
    end
    $display("[rstmid] after release edge4=%h edge5=%h", seen[4], seen[5]);
    checks++;
    if (seen[4] !== 8'hFF || seen[5] !== 8'h00) begin
      $display("FAIL rstmid_blink edge4=%h edge5=%h expected=ff 00", seen[4], seen[5]); errors++;
    end
  endtask

  task automatic test_random();
    int bad;
    for (int blk = 0; blk < 6; blk++) begin
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) dir = ~dir;
        if ($urandom_range(0, 29) == 0) en = ~en;
        if ($urandom_range(0, 49) == 0) speed = 3'($urandom_range(0, 1));
        clk_step();
        if (prled !== m_led) bad++;
      end
      $display("[random] block %0d mode=%0d en=%0d prled=%h", blk, mode, en, prled);
      checks++;
      if (bad != 0) begin $display("FAIL random_blk%0d mismatches=%0d expected=0", blk, bad); errors++; end
    end
    en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_chase();
    test_count();
    test_breathe();
    test_en_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator: the next-generation board-status blinker. It drives N_LED board LEDs in one of four runtime-selectable modes: blink, chase, binary count or PWM breathe. Step rate comes from a programmable prescaler. It sits at the top of each example design, directly on the LED pins, and is fully synchronous to the board clock.

## Interface
- N_LED, 8: number of LED outputs (2..32).
- STEP_DIV, 1_000_000: base prescaler period in clk cycles (≥2); benches override it small.
- PWM_BITS, 8: breathe-mode duty/PWM counter width.
- LED_ACTIVE_LOW, 1: 1 means a driven 0 lights the LED.
- clk  in  1  board clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset; one clock domain only.
- en  in  1  1 = run; 0 = freeze prescaler and pattern, all LEDs off.
- mode  in  2  0 BLINK, 1 CHASE, 2 COUNT, 3 BREATHE.
- speed  in  3  step period = STEP_DIV << speed cycles.
- dir  in  1  CHASE direction: 0 toward MSB, 1 toward LSB.
- prled  out  N_LED  LED pins, registered, polarity per LED_ACTIVE_LOW.

## Operation
- Reset values:
  - prescaler = 0, mode_q = BLINK, speed_q = 0, pattern = all off, duty = 0 rising, pwm_cnt = 0.
  - prled = all 1 when LED_ACTIVE_LOW, else all 0.
- Prescaler:
  - Counts 0..(STEP_DIV<<speed_q)-1, then wraps.
  - tick is a 1-cycle pulse on the wrap cycle.
  - speed_q loads from speed only on tick. A speed change therefore never truncates or stretches the current step.
- Mode change:
  - On a tick with mode != mode_q, mode_q <= mode and the pattern is initialised; no step is taken on that tick.
  - Init states: BLINK all off; CHASE one-hot bit 0 (dir=0) or bit N_LED-1 (dir=1); COUNT 0; BREATHE duty 0, rising.
- Step on a tick with mode == mode_q:
  - BLINK: toggle all-off/all-on.
  - CHASE: rotate one-hot by one position per dir, wrapping MSB→bit 0 and bit 0→MSB. dir is sampled per tick.
  - COUNT: pattern + 1 mod 2^N_LED.
  - BREATHE: duty ±1. On reaching 2^PWM_BITS-1 while rising, the direction flips to falling. On reaching 0 while falling, it flips to rising. Endpoints are held for exactly one step each.
- BREATHE output:
  - pwm_cnt is a free-running PWM_BITS counter, advancing every cycle while en=1.
  - All LEDs are lit while pwm_cnt < duty. Duty 0 is fully dark; max duty is lit for (2^PWM_BITS-1) of every 2^PWM_BITS cycles.
- en=0:
  - Prescaler, pwm_cnt and pattern hold.
  - prled shows off from the next edge.
  - On en=1, operation resumes from the held counts.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). Release is synchronous to clk.

## Timing
- tick → prled shows the new pattern on the next rising edge (1-cycle latency).
- After rst release, the first tick occurs STEP_DIV cycles later (speed_q = 0).
- Changing mode or speed takes effect only at a tick boundary; worst-case latency is one full step period.
- en falling → prled off one cycle later. en rising → the pattern is visible one cycle later.
- A BREATHE duty update applies from the PWM cycle in progress; no glitch-free PWM-period alignment is required.

## Structure
- Package led_pkg:
  - led_mode_t enum (MODE_BLINK, MODE_CHASE, MODE_COUNT, MODE_BREATHE).
  - Helper width function for the prescaler: clog2(STEP_DIV)+7 bits.
- Sub-module led_tick_gen: prescaler plus speed_q latch, producing tick.
- Pattern FSM, PWM and output register live in led_pattern_gen.

## Test plan
Bench parameters: STEP_DIV=4, N_LED=8, PWM_BITS=4, LED_ACTIVE_LOW=1, en=1 unless stated.
- Reset/BLINK, speed=0: prled=8'hFF during reset; first tick at cycle 4 after release, prled=8'h00 at cycle 5; back to 8'hFF 4 cycles later.
- CHASE, dir=0: 8'hFE after the init tick, then 8'hFD, 8'hFB… 8'h7F, 8'hFE. Flip dir mid-run and check the rotation reverses on the next tick.
- COUNT, speed=2 (16-cycle steps):
  - prled = ~count, with count incrementing every 16 cycles.
  - Starting from 8'hFF (count = 0), after 256 steps it wraps back to 8'hFF.
  - A speed change mid-step takes effect only after the current 16-cycle step.
- BREATHE:
  - Duty ramps 0→15→0.
  - At duty 0, prled stays 8'hFF for a full 16-cycle PWM period.
  - At duty 15, prled=8'h00 for 15 of 16 cycles.
- en=0 mid-CHASE: prled=8'hFF next cycle with the pattern held; on en=1, the same one-hot reappears and stepping resumes with the remaining prescaler count.
- rst asserted mid-COUNT: prled=8'hFF asynchronously, and after release mode_q is BLINK until the first tick.
